// File: rtl/viterbi_pkg.sv
// Trellis constants and encoder helpers shared by the K=7, rate-1/2 Viterbi decoder blocks.
package viterbi_pkg;

   localparam int K        = 7;
   localparam int N_STATES = 2 ** (K - 1);

   localparam logic [K-1:0] G0 = 7'b1111001;  // octal 171
   localparam logic [K-1:0] G1 = 7'b1011011;  // octal 133

   // Encoder output {c1, c0} for the branch leaving predecessor p on input u.
   function automatic logic [1:0] enc_out(input logic [K-2:0] p, input logic u);
      logic [K-1:0] r;
      r = {p, u};
      return {^(r & G1), ^(r & G0)};
   endfunction

   // Hamming distance between received pair and code pair, as {and, xor} of the bit errors.
   function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic [1:0] code);
      logic [1:0] x;
      x = rx ^ code;
      return {x[0] & x[1], x[0] ^ x[1]};
   endfunction

endpackage

// File: rtl/acs_cell.sv
// One add-compare-select butterfly half: picks the cheaper of two predecessor paths.
module acs_cell
   import viterbi_pkg::*;
#(
   parameter int PM_W = 8
) (
   input  logic [PM_W-1:0] pm0,
   input  logic [PM_W-1:0] pm1,
   input  logic [1:0]      bm0,
   input  logic [1:0]      bm1,
   output logic [PM_W:0]   sel_pm,
   output logic            dec
);

   logic [PM_W:0] m0;
   logic [PM_W:0] m1;

   // One guard bit so the sum never wraps before the normalization decision.
   assign m0 = {1'b0, pm0} + {{(PM_W - 1){1'b0}}, bm0};
   assign m1 = {1'b0, pm1} + {{(PM_W - 1){1'b0}}, bm1};

   // Strict compare: equal sums keep the p0 branch.
   assign dec    = (m1 < m0);
   assign sel_pm = dec ? m1 : m0;

endmodule

// File: rtl/acs_array.sv
// Fully parallel 64-state ACS stage: input register, ACS/normalize/argmin, registered metrics
// and decision outputs. One symbol per cycle, results one edge after the symbol is captured.
module acs_array
   import viterbi_pkg::*;
#(
   parameter int PM_W    = 8,
   parameter int PM_INIT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [1:0]  rx_pair,
   input  logic        frame_start,
   output logic        dec_valid,
   output logic [63:0] dec_bits,
   output logic [5:0]  best_state,
   output logic        norm_event
);

   localparam int              SW         = $clog2(N_STATES);
   localparam int              NODES      = 2 * N_STATES - 1;
   localparam logic [PM_W-1:0] PM_RESTART = PM_W'(PM_INIT);

   logic                sym_valid;
   logic [1:0]          sym_rx;
   logic                sym_fs;

   logic [PM_W-1:0]     pm      [N_STATES];
   logic [PM_W-1:0]     pm_src  [N_STATES];
   logic [PM_W:0]       sel_pm  [N_STATES];
   logic [PM_W-1:0]     pm_next [N_STATES];
   logic [N_STATES-1:0] dec;
   logic                norm;

   logic [PM_W:0]       tree_val [NODES];
   logic [SW-1:0]       tree_idx [NODES];
   logic [SW-1:0]       best;

   // NOTE: sequential state is written with non-blocking assignments so every register
   // samples the pre-edge values, independent of the order the always_ff blocks run in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sym_valid <= 1'b0;
         sym_rx    <= 2'b00;
         sym_fs    <= 1'b0;
      end else begin
         sym_valid <= in_valid;
         if (in_valid) begin
            sym_rx <= rx_pair;
            sym_fs <= frame_start;
         end
      end
   end

   // A frame restart replaces the stored metrics with the reset profile for this symbol only.
   always_comb begin
      for (int s = 0; s < N_STATES; s++) begin
         pm_src[s] = sym_fs ? ((s == 0) ? '0 : PM_RESTART) : pm[s];
      end
   end

   for (genvar g = 0; g < N_STATES; g++) begin : g_acs
      localparam logic [SW-1:0] P0 = SW'(g >> 1);
      localparam logic [SW-1:0] P1 = SW'((g >> 1) + N_STATES / 2);
      localparam logic          U  = 1'(g % 2);

      logic [1:0] bm0;
      logic [1:0] bm1;

      assign bm0 = branch_metric(sym_rx, enc_out(P0, U));
      assign bm1 = branch_metric(sym_rx, enc_out(P1, U));

      acs_cell #(
         .PM_W (PM_W)
      ) u_cell (
         .pm0    (pm_src[P0]),
         .pm1    (pm_src[P1]),
         .bm0    (bm0),
         .bm1    (bm1),
         .sel_pm (sel_pm[g]),
         .dec    (dec[g])
      );
   end

   // NOTE: every combinational output gets a value on every path before any conditional
   // update, so no latch can be inferred.
   always_comb begin
      norm = 1'b1;
      for (int s = 0; s < N_STATES; s++) begin
         norm = norm & sel_pm[s][PM_W-1];
      end
      for (int s = 0; s < N_STATES; s++) begin
         pm_next[s] = sel_pm[s][PM_W-1:0];
         if (norm) begin
            pm_next[s][PM_W-1] = 1'b0;
         end
      end
   end

   // Heap-ordered min tree on pre-normalization sums (same order as the stored metrics).
   // Left children always cover lower state indices, so ties resolve to the lowest index.
   always_comb begin
      for (int s = 0; s < N_STATES; s++) begin
         tree_val[N_STATES - 1 + s] = sel_pm[s];
         tree_idx[N_STATES - 1 + s] = SW'(s);
      end
      for (int n = N_STATES - 2; n >= 0; n--) begin
         if (tree_val[2 * n + 2] < tree_val[2 * n + 1]) begin
            tree_val[n] = tree_val[2 * n + 2];
            tree_idx[n] = tree_idx[2 * n + 2];
         end else begin
            tree_val[n] = tree_val[2 * n + 1];
            tree_idx[n] = tree_idx[2 * n + 1];
         end
      end
   end

   assign best = tree_idx[0];

   // NOTE: the metric bank is reset explicitly because decoding must start from the
   // known state-0 profile; it is a register bank, not a RAM, so this costs nothing extra.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < N_STATES; s++) begin
            pm[s] <= (s == 0) ? '0 : PM_RESTART;
         end
      end else if (sym_valid) begin
         for (int s = 0; s < N_STATES; s++) begin
            pm[s] <= pm_next[s];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_valid  <= 1'b0;
         norm_event <= 1'b0;
         dec_bits   <= '0;
         best_state <= '0;
      end else begin
         dec_valid  <= sym_valid;
         norm_event <= sym_valid & norm;
         if (sym_valid) begin
            dec_bits   <= dec;
            best_state <= best;
         end
      end
   end

endmodule

// File: tb/tb_acs_array.sv
// Self-checking bench for acs_array against an integer trellis model of the decoder ACS.
module tb_acs_array;

   localparam int PM_W    = 8;
   localparam int PM_INIT = 64;
   localparam int HALF    = 1 << (PM_W - 1);

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [1:0]  rx_pair;
   logic        frame_start;
   logic        dec_valid;
   logic [63:0] dec_bits;
   logic [5:0]  best_state;
   logic        norm_event;

   always #5 clk = ~clk;

   acs_array #(
      .PM_W    (PM_W),
      .PM_INIT (PM_INIT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .rx_pair     (rx_pair),
      .frame_start (frame_start),
      .dec_valid   (dec_valid),
      .dec_bits    (dec_bits),
      .best_state  (best_state),
      .norm_event  (norm_event)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state and expected outputs
   int          m_pm [64];
   logic [63:0] exp_dec;
   logic [5:0]  exp_best;
   logic        exp_norm;
   logic        exp_valid;
   logic [63:0] tie_mask;
   bit          prev_sent;
   logic [1:0]  prev_rx;
   bit          prev_fs;

   // sampled DUT observations
   logic            obs_valid;
   logic            obs_norm;
   logic [5:0]      obs_best;
   logic [63:0]     obs_dec;
   logic [PM_W-1:0] obs_pm [64];

   function automatic int parity(input int v);
      int c = 0;
      for (int k = 0; k < 7; k++) c = c ^ ((v >> k) & 1);
      return c;
   endfunction

   // {c1, c0} of a shift-register encoder holding 6 past bits 'st' and new bit u
   function automatic logic [1:0] enc_pair(input int st, input int u);
      int r;
      r = st * 2 + u;
      return {1'(parity(r & 'o133)), 1'(parity(r & 'o171))};
   endfunction

   function automatic int hdist(input int rx, input int st, input int u);
      logic [1:0] c;
      c = enc_pair(st, u);
      return (((rx & 1) != int'(c[0])) ? 1 : 0) + ((((rx >> 1) & 1) != int'(c[1])) ? 1 : 0);
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 64; s++) m_pm[s] = (s == 0) ? 0 : PM_INIT;
      exp_dec   = '0;
      exp_best  = '0;
      exp_norm  = 1'b0;
      exp_valid = 1'b0;
      prev_sent = 0;
   endtask

   task automatic model_step(input logic [1:0] rx, input bit fs);
      int base [64];
      int nxt  [64];
      int a, b, mn, p0;
      for (int s = 0; s < 64; s++) base[s] = fs ? ((s == 0) ? 0 : PM_INIT) : m_pm[s];
      mn       = 1 << 30;
      exp_dec  = '0;
      tie_mask = '0;
      for (int ns = 0; ns < 64; ns++) begin
         p0 = ns / 2;
         a  = base[p0] + hdist(int'(rx), p0, ns % 2);
         b  = base[p0 + 32] + hdist(int'(rx), p0 + 32, ns % 2);
         nxt[ns] = (b < a) ? b : a;
         if (b < a)  exp_dec[ns]  = 1'b1;
         if (a == b) tie_mask[ns] = 1'b1;
         if (nxt[ns] < mn) begin
            mn       = nxt[ns];
            exp_best = 6'(ns);
         end
      end
      exp_norm = (mn >= HALF);
      for (int s = 0; s < 64; s++) m_pm[s] = nxt[s] - (exp_norm ? HALF : 0);
   endtask

   // drive one cycle of input, advance one edge, sample on the falling edge
   task automatic tick(input bit v, input logic [1:0] rx, input bit fs);
      in_valid    = v;
      rx_pair     = rx;
      frame_start = fs;
      @(posedge clk);
      @(negedge clk);
      obs_valid = dec_valid;
      obs_norm  = norm_event;
      obs_best  = best_state;
      obs_dec   = dec_bits;
      for (int s = 0; s < 64; s++) obs_pm[s] = dut.pm[s];
      exp_valid = prev_sent;
      exp_norm  = 1'b0;
      if (prev_sent) model_step(prev_rx, prev_fs);
      prev_sent = v;
      prev_rx   = rx;
      prev_fs   = fs;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; rx_pair = 2'b00; frame_start = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if ({dec_valid, norm_event, best_state, dec_bits} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got valid=%b norm=%b best=%0d dec=%h want all zero",
                  dec_valid, norm_event, best_state, dec_bits);
      end
      n_checks++;
      if (dut.pm[0] !== 8'd0 || dut.pm[5] !== 8'd64) begin
         n_fail++;
         $display("FAIL reset_pm got pm0=%0d pm5=%0d want 0 and 64", dut.pm[0], dut.pm[5]);
      end
      rst = 1'b0;
      tick(0, 2'b00, 0);
      n_checks++;
      if (obs_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_valid got %b want 0", obs_valid);
      end
   endtask

   task automatic test_single_zero();
      tick(1, 2'b00, 0);
      n_checks++;
      if (obs_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_early_valid got %b want 0", obs_valid);
      end
      tick(0, 2'b00, 0);
      n_checks++;
      if (obs_valid !== 1'b1 || obs_dec[0] !== 1'b0 || obs_best !== 6'd0) begin
         n_fail++;
         $display("FAIL single_out got valid=%b dec0=%b best=%0d want 1 0 0", obs_valid, obs_dec[0], obs_best);
      end
      n_checks++;
      if (obs_pm[0] !== 8'd0 || obs_pm[32] !== PM_W'(m_pm[32]) || obs_dec !== exp_dec) begin
         n_fail++;
         $display("FAIL single_pm got pm0=%0d pm32=%0d dec=%h want 0 %0d %h",
                  obs_pm[0], obs_pm[32], obs_dec, m_pm[32], exp_dec);
      end
      tick(0, 2'b00, 0);
      n_checks++;
      if (obs_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_pulse_width got %b want 0", obs_valid);
      end
   endtask

   task automatic test_zero_run();
      for (int i = 0; i <= 100; i++) begin
         tick(i < 100, 2'b00, 0);
         n_checks++;
         if (obs_best !== 6'd0 || obs_pm[0] !== 8'd0 || obs_norm !== 1'b0 || obs_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL zero_run[%0d] got best=%0d pm0=%0d norm=%b valid=%b want 0 0 0 %b",
                     i, obs_best, obs_pm[0], obs_norm, obs_valid, exp_valid);
         end
      end
   endtask

   task automatic test_tie();
      int bad;
      tick(1, 2'b01, 1);
      tick(0, 2'b00, 0);
      n_checks++;
      if (tie_mask == '0 || (obs_dec & tie_mask) !== '0) begin
         n_fail++;
         $display("FAIL tie_select got dec=%h ties=%h want no dec bit set on a tie", obs_dec, tie_mask);
      end
      n_checks++;
      if (obs_valid !== exp_valid || obs_best !== exp_best || obs_dec !== exp_dec || obs_norm !== exp_norm) begin
         n_fail++;
         $display("FAIL tie_out got valid=%b best=%0d dec=%h norm=%b want %b %0d %h %b",
                  obs_valid, obs_best, obs_dec, obs_norm, exp_valid, exp_best, exp_dec, exp_norm);
      end
      bad = -1;
      for (int s = 0; s < 64; s++) if (obs_pm[s] !== PM_W'(m_pm[s])) bad = s;
      n_checks++;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL tie_pm[%0d] got %0d want %0d", bad, obs_pm[bad], m_pm[bad]);
      end
   endtask

   task automatic test_normalization();
      int bad;
      int norm_seen = 0;
      int i = 0;
      while (i < 300 || (norm_seen == 0 && i < 4000)) begin
         tick(1, (i < 300) ? 2'b11 : 2'($urandom_range(0, 3)), 0);
         if (obs_norm === 1'b1) norm_seen++;
         n_checks++;
         if (obs_valid !== exp_valid || obs_best !== exp_best || obs_dec !== exp_dec || obs_norm !== exp_norm) begin
            n_fail++;
            $display("FAIL norm_out[%0d] got valid=%b best=%0d dec=%h norm=%b want %b %0d %h %b",
                     i, obs_valid, obs_best, obs_dec, obs_norm, exp_valid, exp_best, exp_dec, exp_norm);
         end
         bad = -1;
         for (int s = 0; s < 64; s++) if (obs_pm[s] !== PM_W'(m_pm[s])) bad = s;
         n_checks++;
         if (bad >= 0) begin
            n_fail++;
            $display("FAIL norm_pm[%0d] state %0d got %0d want %0d", i, bad, obs_pm[bad], m_pm[bad]);
         end
         i++;
      end
      tick(0, 2'b00, 0);
      n_checks++;
      if (norm_seen == 0) begin
         n_fail++;
         $display("FAIL norm_event_seen got 0 pulses in %0d symbols want at least 1", i);
      end
   endtask

   task automatic test_gaps_restart();
      int         enc_s = 0;
      int         u, e, gaps, bad;
      logic [1:0] sym;
      for (int i = 0; i < 200; i++) begin
         if (i == 100) enc_s = 0;
         u     = int'($urandom_range(0, 1));
         sym   = enc_pair(enc_s, u);
         enc_s = ((enc_s << 1) | u) & 63;
         if (i % 20 == 9) begin
            e      = int'($urandom_range(0, 1));
            sym[e] = ~sym[e];
         end
         gaps = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
         for (int g = 0; g <= gaps; g++) begin
            if (g == 0) tick(1, sym, (i == 0) || (i == 100));
            else        tick(0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            n_checks++;
            if (obs_valid !== exp_valid || obs_best !== exp_best || obs_dec !== exp_dec || obs_norm !== exp_norm) begin
               n_fail++;
               $display("FAIL gaps_out[%0d.%0d] got valid=%b best=%0d dec=%h norm=%b want %b %0d %h %b",
                        i, g, obs_valid, obs_best, obs_dec, obs_norm, exp_valid, exp_best, exp_dec, exp_norm);
            end
            bad = -1;
            for (int s = 0; s < 64; s++) if (obs_pm[s] !== PM_W'(m_pm[s])) bad = s;
            n_checks++;
            if (bad >= 0) begin
               n_fail++;
               $display("FAIL gaps_pm[%0d.%0d] state %0d got %0d want %0d", i, g, bad, obs_pm[bad], m_pm[bad]);
            end
         end
      end
      tick(0, 2'b00, 0);
      n_checks++;
      if (obs_valid !== exp_valid || obs_best !== exp_best || obs_dec !== exp_dec) begin
         n_fail++;
         $display("FAIL gaps_flush got valid=%b best=%0d dec=%h want %b %0d %h",
                  obs_valid, obs_best, obs_dec, exp_valid, exp_best, exp_dec);
      end
   endtask

   task automatic test_reset_midstream();
      int bad;
      for (int i = 0; i < 6; i++) tick(1, 2'($urandom_range(0, 3)), 0);
      in_valid    = 1'b1;
      rx_pair     = 2'($urandom_range(0, 3));
      frame_start = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({dec_valid, norm_event, best_state, dec_bits} !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs got valid=%b norm=%b best=%0d dec=%h want all zero",
                  dec_valid, norm_event, best_state, dec_bits);
      end
      bad = -1;
      for (int s = 0; s < 64; s++) if (dut.pm[s] !== ((s == 0) ? 8'd0 : 8'(PM_INIT))) bad = s;
      n_checks++;
      if (dut.pm[0] !== 8'd0 || dut.pm[5] !== 8'd64 || bad >= 0) begin
         n_fail++;
         $display("FAIL midreset_pm got pm0=%0d pm5=%0d first_bad=%0d want 0 64 none", dut.pm[0], dut.pm[5], bad);
      end
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         tick(0, 2'b00, 0);
         n_checks++;
         if (obs_valid !== 1'b0 || obs_dec !== '0 || obs_best !== 6'd0) begin
            n_fail++;
            $display("FAIL midreset_discard[%0d] got valid=%b dec=%h best=%0d want 0 0 0",
                     i, obs_valid, obs_dec, obs_best);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_zero();
      test_zero_run();
      test_tie();
      test_normalization();
      test_gaps_restart();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
